// File: rtl/mem_target.sv
// mem_target: responder on the CPU memory port. A byte-maskable word RAM
// plus an MMIO page (LED register, free-running cycle counter, sticky
// status), with an optional number of read wait states.
module mem_target #(
    parameter int    DEPTH     = 4096,
    parameter int    WAIT      = 0,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren,
    input  logic [15:0] addr,
    output logic [31:0] rdata,
    output logic        rd_valid,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic        busy,
    output logic [7:0]  led,
    output logic        fault
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = (WAIT < 1) ? 1 : $clog2(WAIT + 1);
    localparam logic [16:0] RAM_END = 17'(DEPTH * 4);

    typedef enum logic [2:0] {R_RAM, R_LED, R_CYC, R_STAT, R_BAD} region_t;
    typedef enum logic [1:0] {S_IDLE, S_WAITING, S_DONE} state_t;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   cycles;
    logic          overrun;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          rd_valid_q;

    // Request captured at accept time (used only when WAIT > 0)
    logic          lat_ram;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_mmio;

    region_t       a_reg;
    logic [AW-1:0] a_idx;
    logic [31:0]   a_mmio;
    logic          req_ok;
    logic          rd_go;
    logic          go_ram;
    logic [AW-1:0] go_idx;
    logic [31:0]   go_mmio;
    logic          fault_set, ovr_set, stat_clr;

    // RAM wins below DEPTH*4; the MMIO words are decoded only above it, so
    // out-of-range RAM addresses fall through to R_BAD instead of aliasing.
    function automatic region_t decode(input logic [15:0] a);
        region_t r;
        r = R_BAD;
        if ({1'b0, a} < RAM_END) begin
            r = R_RAM;
        end else begin
            case (a[15:2])
                14'h3C00: r = R_LED;
                14'h3C01: r = R_CYC;
                14'h3C02: r = R_STAT;
                default:  r = R_BAD;
            endcase
        end
        return r;
    endfunction

    // Address decode and MMIO read value as seen at request time
    always_comb begin
        a_reg = decode(addr);
        a_idx = addr[AW+1:2];
        case (a_reg)
            R_LED:   a_mmio = {24'd0, led};
            R_CYC:   a_mmio = cycles;
            R_STAT:  a_mmio = {30'd0, overrun, fault};
            default: a_mmio = 32'd0;
        endcase
    end

    // A read is accepted only when no write shares the edge and nothing is pending;
    // it completes immediately (WAIT=0) or when the wait counter expires.
    always_comb begin
        req_ok = ren && !wen && !busy;
        if (WAIT == 0) begin
            rd_go   = req_ok;
            go_ram  = (a_reg == R_RAM);
            go_idx  = a_idx;
            go_mmio = a_mmio;
        end else begin
            rd_go   = (state == S_WAITING) && (cnt == CW'(1));
            go_ram  = lat_ram;
            go_idx  = lat_idx;
            go_mmio = lat_mmio;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state; completion happens on the edge where the counter leaves 1,
    // which gives exactly WAIT busy cycles and a 1+WAIT read latency.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: state_nxt = (req_ok && WAIT > 0) ? S_WAITING : S_IDLE;
            S_WAITING:      if (cnt == CW'(1)) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy     = (state == S_WAITING);
        rd_valid = (WAIT == 0) ? rd_valid_q : (state == S_DONE);
    end

    // Wait counter and request latch; CYCLES/STATUS are sampled here at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            lat_ram  <= 1'b0;
            lat_idx  <= '0;
            lat_mmio <= '0;
        end else if (req_ok) begin
            cnt      <= CW'(WAIT);
            lat_ram  <= (a_reg == R_RAM);
            lat_idx  <= a_idx;
            lat_mmio <= a_mmio;
        end else if (state == S_WAITING) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Read data register; holds its value until the next read completes
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= (WAIT == 0) && req_ok;
            if (rd_go) rdata <= go_ram ? mem[go_idx] : go_mmio;
        end
    end

    // RAM byte-lane writes; wmask bit order is reversed relative to lanes
    always_ff @(posedge clk) begin
        if (wen && a_reg == R_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[3-i]) mem[a_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Free-running cycle counter
    always_ff @(posedge clk) begin
        if (rst) cycles <= '0;
        else     cycles <= cycles + 32'd1;
    end

    // Status set/clear terms; a new event wins over a same-cycle clear
    always_comb begin
        fault_set = (ren && wen) || (req_ok && a_reg == R_BAD) || (wen && a_reg == R_BAD);
        ovr_set   = ren && busy;
        stat_clr  = wen && wmask[3] && (a_reg == R_STAT);
    end

    // LED register and sticky status bits
    always_ff @(posedge clk) begin
        if (rst) begin
            led     <= '0;
            fault   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (wen && wmask[3] && a_reg == R_LED) led <= wdata[7:0];
            fault   <= (fault   && !(stat_clr && wdata[0])) || fault_set;
            overrun <= (overrun && !(stat_clr && wdata[1])) || ovr_set;
        end
    end

endmodule

// File: tb/tb_mem_target.sv
// Directed bench for mem_target: three instances (WAIT=0, 2, 3) share the
// clock and address/data buses; each has its own rst/ren/wen.
module tb_mem_target;
    logic        clk = 1'b0;
    logic [2:0]  rst, ren, wen;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata [3];
    logic [2:0]  rd_valid, busy, fault;
    logic [7:0]  led [3];

    int npass = 0;
    int nchk  = 0;
    logic seen;

    always #5 clk = ~clk;

    mem_target #(.DEPTH(4096), .WAIT(0)) u0 (
        .clk(clk), .rst(rst[0]), .ren(ren[0]), .addr(addr), .rdata(rdata[0]),
        .rd_valid(rd_valid[0]), .wen(wen[0]), .wdata(wdata), .wmask(wmask),
        .busy(busy[0]), .led(led[0]), .fault(fault[0]));
    mem_target #(.DEPTH(4096), .WAIT(2)) u2 (
        .clk(clk), .rst(rst[1]), .ren(ren[1]), .addr(addr), .rdata(rdata[1]),
        .rd_valid(rd_valid[1]), .wen(wen[1]), .wdata(wdata), .wmask(wmask),
        .busy(busy[1]), .led(led[1]), .fault(fault[1]));
    mem_target #(.DEPTH(4096), .WAIT(3)) u3 (
        .clk(clk), .rst(rst[2]), .ren(ren[2]), .addr(addr), .rdata(rdata[2]),
        .rd_valid(rd_valid[2]), .wen(wen[2]), .wdata(wdata), .wmask(wmask),
        .busy(busy[2]), .led(led[2]), .fault(fault[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 3'b111; ren = '0; wen = '0; addr = '0; wdata = '0; wmask = '0;
        tick(); tick();
        check("rst_rdata",   rdata[0], 32'h0);
        check("rst_valid",   {31'd0, rd_valid[0]}, 32'h0);
        check("rst_led",     {24'd0, led[0]}, 32'h0);
        check("rst_fault",   {31'd0, fault[0]}, 32'h0);
        check("rst_busy2",   {31'd0, busy[1]}, 32'h0);

        // cycle counter: first non-reset edge samples 0, ten edges later 10
        rst = 3'b000; ren[0] = 1'b1; addr = 16'hF004;
        tick();
        check("cyc_first",   rdata[0], 32'd0);
        check("cyc_valid",   {31'd0, rd_valid[0]}, 32'h1);
        ren[0] = 1'b0;
        tick();
        check("valid_pulse", {31'd0, rd_valid[0]}, 32'h0);
        check("rdata_hold",  rdata[0], 32'd0);
        repeat (8) tick();
        ren[0] = 1'b1;
        tick();
        check("cyc_plus10",  rdata[0], 32'd10);
        ren[0] = 1'b0;

        // counter wrap
        force u0.cycles = 32'hFFFF_FFFF;
        tick();
        release u0.cycles;
        ren[0] = 1'b1; addr = 16'hF004;
        tick();
        check("cyc_max",     rdata[0], 32'hFFFF_FFFF);
        tick();
        check("cyc_wrap",    rdata[0], 32'h0);
        ren[0] = 1'b0;

        // RAM byte-lane write
        wen[0] = 1'b1; addr = 16'h0010; wdata = 32'hAABB_CCDD; wmask = 4'b1111;
        tick();
        wdata = 32'h0000_0011; wmask = 4'b1000;
        tick();
        wen[0] = 1'b0; ren[0] = 1'b1;
        tick();
        check("byte_wr",     rdata[0], 32'hAABB_CC11);
        check("byte_valid",  {31'd0, rd_valid[0]}, 32'h1);
        ren[0] = 1'b0;
        tick();
        check("byte_pulse",  {31'd0, rd_valid[0]}, 32'h0);
        check("byte_hold",   rdata[0], 32'hAABB_CC11);

        // half write via offset address, then back-to-back reads
        wen[0] = 1'b1; addr = 16'h0012; wdata = 32'h5566_0000; wmask = 4'b0011;
        tick();
        addr = 16'h0014; wdata = 32'h1234_5678; wmask = 4'b1111;
        tick();
        wen[0] = 1'b0; ren[0] = 1'b1; addr = 16'h0010;
        tick();
        check("half_wr",     rdata[0], 32'h5566_CC11);
        addr = 16'h0014;
        tick();
        check("b2b_second",  rdata[0], 32'h1234_5678);
        check("b2b_valid",   {31'd0, rd_valid[0]}, 32'h1);
        ren[0] = 1'b0;

        // last RAM word
        wen[0] = 1'b1; addr = 16'h3FFC; wdata = 32'hCAFE_F00D; wmask = 4'b1111;
        tick();
        wen[0] = 1'b0; ren[0] = 1'b1;
        tick();
        check("ram_top",     rdata[0], 32'hCAFE_F00D);
        check("ram_top_flt", {31'd0, fault[0]}, 32'h0);
        ren[0] = 1'b0;

        // LED: needs wmask[3]
        wen[0] = 1'b1; addr = 16'hF000; wdata = 32'h0000_01A5; wmask = 4'b1000;
        tick();
        check("led_wr",      {24'd0, led[0]}, 32'hA5);
        wdata = 32'h0000_003C; wmask = 4'b0111;
        tick();
        check("led_masked",  {24'd0, led[0]}, 32'hA5);
        wen[0] = 1'b0; ren[0] = 1'b1;
        tick();
        check("led_rd",      rdata[0], 32'h0000_00A5);
        ren[0] = 1'b0;

        // unmapped read, W1C clear, out-of-range write at DEPTH*4
        ren[0] = 1'b1; addr = 16'h8000;
        tick();
        check("bad_rdata",   rdata[0], 32'h0);
        check("bad_fault",   {31'd0, fault[0]}, 32'h1);
        ren[0] = 1'b0; wen[0] = 1'b1; addr = 16'hF008; wdata = 32'h1; wmask = 4'b1000;
        tick();
        check("w1c_fault",   {31'd0, fault[0]}, 32'h0);
        addr = 16'h4000; wdata = 32'hFFFF_FFFF; wmask = 4'b1111;
        tick();
        check("oor_wr",      {31'd0, fault[0]}, 32'h1);
        addr = 16'hF008; wdata = 32'h1; wmask = 4'b1000;
        tick();
        addr = 16'hF004; wdata = 32'h0; wmask = 4'b1111;
        tick();
        check("cyc_wr_ok",   {31'd0, fault[0]}, 32'h0);

        // collision: write lands, read dropped, fault set
        ren[0] = 1'b1; wen[0] = 1'b1; addr = 16'h0020; wdata = 32'hDEAD_BEEF; wmask = 4'b1111;
        tick();
        check("col_valid",   {31'd0, rd_valid[0]}, 32'h0);
        check("col_fault",   {31'd0, fault[0]}, 32'h1);
        wen[0] = 1'b0;
        tick();
        check("col_wr",      rdata[0], 32'hDEAD_BEEF);
        ren[0] = 1'b0;

        // WAIT=2: busy two cycles, valid on the third, overrun on busy ren
        wen[1] = 1'b1; addr = 16'h0000; wdata = 32'h0102_0304; wmask = 4'b1111;
        tick();
        wen[1] = 1'b0; ren[1] = 1'b1;
        tick();
        check("w2_busy1",    {30'd0, busy[1], rd_valid[1]}, 32'h2);
        tick();
        check("w2_busy2",    {30'd0, busy[1], rd_valid[1]}, 32'h2);
        ren[1] = 1'b0;
        tick();
        check("w2_done",     {30'd0, busy[1], rd_valid[1]}, 32'h1);
        check("w2_rdata",    rdata[1], 32'h0102_0304);
        tick();
        check("w2_idle",     {30'd0, busy[1], rd_valid[1]}, 32'h0);
        ren[1] = 1'b1; addr = 16'hF008;
        tick();
        ren[1] = 1'b0;
        tick(); tick();
        check("w2_stat_vld", {31'd0, rd_valid[1]}, 32'h1);
        check("w2_overrun",  rdata[1], 32'h2);

        // WAIT=3: load rdata/led, then reset one cycle into a read
        wen[2] = 1'b1; addr = 16'h0030; wdata = 32'h0BAD_F00D; wmask = 4'b1111;
        tick();
        addr = 16'hF000; wdata = 32'h5A; wmask = 4'b1000;
        tick();
        wen[2] = 1'b0; ren[2] = 1'b1; addr = 16'h0030;
        tick();
        ren[2] = 1'b0;
        tick(); tick(); tick();
        check("w3_rd",       rdata[2], 32'h0BAD_F00D);
        check("w3_rd_vld",   {31'd0, rd_valid[2]}, 32'h1);
        ren[2] = 1'b1;
        tick();
        check("w3_busy",     {31'd0, busy[2]}, 32'h1);
        ren[2] = 1'b0; rst[2] = 1'b1;
        tick();
        check("w3_rst_busy", {31'd0, busy[2]}, 32'h0);
        check("w3_rst_led",  {24'd0, led[2]}, 32'h0);
        check("w3_rst_rd",   rdata[2], 32'h0);
        rst[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | rd_valid[2];
        end
        check("w3_no_valid", {31'd0, seen}, 32'h0);
        ren[2] = 1'b1;
        tick();
        ren[2] = 1'b0;
        tick(); tick(); tick();
        check("w3_retained", rdata[2], 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
